// File: rtl/pipeline_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_defines
// Shared constants for the 5-stage pipeline sequencer.
//   - per-stage stall masks (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM,
//     bit5 WB; 1 = hold that stage)
//   - sequencer state encoding (RUN / FLUSH)
//   - stall vector bit positions
// Imported by pipeline_controller and stall_watchdog.
// ---------------------------------------------------------------------------
package pipeline_defines;

  // A stall from a stage freezes that stage and everything upstream of it,
  // so younger instructions wait while older ones keep draining.
  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_FROM_ID = 6'b000111;
  localparam logic [5:0] STALL_FROM_EX = 6'b001111;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam int STALL_BIT_PC  = 0;
  localparam int STALL_BIT_IF  = 1;
  localparam int STALL_BIT_ID  = 2;
  localparam int STALL_BIT_EX  = 3;
  localparam int STALL_BIT_MEM = 4;
  localparam int STALL_BIT_WB  = 5;

endpackage

// File: rtl/pipeline_controller_stall_watchdog.sv
// ---------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive cycles in which the PC is held and raises a sticky
// error flag once the count reaches STALL_TIMEOUT (a likely deadlock).
//
// Parameters:
//   STALL_TIMEOUT  consecutive stalled cycles that trip the flag (1..65535)
// Ports:
//   clock             in   system clock, rising edge
//   reset             in   asynchronous active-low reset
//   i_stallPc         in   stall[0] of the pipeline stall vector
//   o_stallTimeout    out  sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module stall_watchdog
  import pipeline_defines::*;
#(
  parameter int STALL_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic i_stallPc,
  output logic o_stallTimeout
);

  localparam logic [15:0] TIMEOUT_VALUE = 16'(STALL_TIMEOUT);

  logic [15:0] r_stallCount;
  logic        r_stallTimeout;

  // Saturating run-length counter of stalled cycles; any unstalled edge
  // restarts the run. The flag is set on the same edge the count lands on
  // the timeout value and never clears on its own.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stallCount   <= 16'd0;
      r_stallTimeout <= 1'b0;
    end else if (i_stallPc) begin
      if (r_stallCount < TIMEOUT_VALUE) begin
        r_stallCount <= r_stallCount + 16'd1;
        if (r_stallCount + 16'd1 == TIMEOUT_VALUE) begin
          r_stallTimeout <= 1'b1;
        end
      end
    end else begin
      r_stallCount <= 16'd0;
    end
  end

  assign o_stallTimeout = r_stallTimeout;

endmodule

// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
// Central sequencer for the IF/ID/EX/MEM/WB pipeline: merges stage stall
// requests into a per-stage stall vector, sequences flushes on exception or
// redirect requests, and runs a consecutive-stall deadlock watchdog.
//
// Parameters:
//   FLUSH_CYCLES   cycles flush stays asserted per redirect (1..15)
//   STALL_TIMEOUT  consecutive stalled cycles that trip the watchdog
// Ports:
//   clock                in   system clock, rising edge
//   reset                in   asynchronous active-low reset
//   stall_request_id     in   load-use hazard in ID
//   stall_request_ex     in   multi-cycle operation busy in EX
//   exception_request    in   one-cycle flush/redirect request
//   exception_vector     in   redirect PC, sampled with exception_request
//   stall[5:0]           out  per-stage hold (bit0 PC .. bit5 WB)
//   flush                out  clear all pipeline registers this cycle
//   new_program_counter  out  redirect PC, valid while flush=1
//   stall_timeout        out  sticky watchdog error flag
// Optional (macro PIPELINE_STALL_COUNTER_EN):
//   stall_count_clear    in   synchronous clear of the stall cycle counter
//   stall_cycle_count    out  free-running count of stalled cycles (wraps)
// ---------------------------------------------------------------------------
module pipeline_controller
  import pipeline_defines::*;
#(
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_request_id,
  input  logic        stall_request_ex,
  input  logic        exception_request,
  input  logic [31:0] exception_vector,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_program_counter,
  output logic        stall_timeout
`ifdef PIPELINE_STALL_COUNTER_EN
  ,
  input  logic        stall_count_clear,
  output logic [31:0] stall_cycle_count
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [0:0]  r_state;
  logic        r_flush;
  logic [31:0] r_newPc;
  logic [3:0]  r_flushCount;
  logic [5:0]  w_stall;

  // Stall vector is purely combinational so a hazard holds the pipe in the
  // same cycle it is detected. An exception wins over any stall so the
  // redirect is never blocked, and the vector is forced quiet during reset.
  always_comb begin
    w_stall = STALL_NONE;
    if (reset && (r_state == RUN) && !exception_request) begin
      if (stall_request_ex) begin
        w_stall = STALL_FROM_EX;
      end else if (stall_request_id) begin
        w_stall = STALL_FROM_ID;
      end
    end
  end

  // Flush sequencer. The counter is preloaded with FLUSH_CYCLES-1 and the
  // state leaves FLUSH on the edge after it reaches zero, giving exactly
  // FLUSH_CYCLES cycles of flush. Requests arriving during FLUSH are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_flush      <= 1'b0;
      r_newPc      <= 32'd0;
      r_flushCount <= 4'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (exception_request) begin
            r_state      <= FLUSH;
            r_flush      <= 1'b1;
            r_newPc      <= exception_vector;
            r_flushCount <= FLUSH_LOAD;
          end
        end
        default: begin
          if (r_flushCount == 4'd0) begin
            r_state <= RUN;
            r_flush <= 1'b0;
          end else begin
            r_flushCount <= r_flushCount - 4'd1;
          end
        end
      endcase
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_stallWatchdog (
    .clock         (clock),
    .reset         (reset),
    .i_stallPc     (w_stall[STALL_BIT_PC]),
    .o_stallTimeout(stall_timeout)
  );

`ifdef PIPELINE_STALL_COUNTER_EN
  logic [31:0] r_stallCycleCount;

  // Performance counter of stalled cycles; clear beats increment and the
  // count wraps naturally at 32 bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stallCycleCount <= 32'd0;
    end else if (stall_count_clear) begin
      r_stallCycleCount <= 32'd0;
    end else if (w_stall[STALL_BIT_PC]) begin
      r_stallCycleCount <= r_stallCycleCount + 32'd1;
    end
  end

  assign stall_cycle_count = r_stallCycleCount;
`endif

  assign stall               = w_stall;
  assign flush               = r_flush;
  assign new_program_counter = r_newPc;

endmodule

// File: tb/tb_pipeline_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_controller
// Directed, table-driven bench for pipeline_controller built with
// FLUSH_CYCLES=2 and STALL_TIMEOUT=4. Each table row holds the inputs for one
// cycle and the outputs expected during that cycle; a few hand-written
// sequences cover asynchronous reset in the middle of a flush and the
// optional stall cycle counter (macro PIPELINE_STALL_COUNTER_EN).
// ---------------------------------------------------------------------------
module tb_pipeline_controller;

  typedef struct {
    logic        rst;
    logic        id;
    logic        ex;
    logic        exc;
    logic [31:0] vec;
    logic [5:0]  expStall;
    logic        expFlush;
    logic [31:0] expPc;
    logic        expTimeout;
  } vector_t;

  logic        clock;
  logic        reset;
  logic        stall_request_id;
  logic        stall_request_ex;
  logic        exception_request;
  logic [31:0] exception_vector;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_program_counter;
  logic        stall_timeout;
`ifdef PIPELINE_STALL_COUNTER_EN
  logic        stall_count_clear;
  logic [31:0] stall_cycle_count;
`endif

  int nCompared;
  int nMismatched;

  vector_t vectors[64];
  int      nRows;

  pipeline_controller #(
    .FLUSH_CYCLES (2),
    .STALL_TIMEOUT(4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .stall_request_id   (stall_request_id),
    .stall_request_ex   (stall_request_ex),
    .exception_request  (exception_request),
    .exception_vector   (exception_vector),
    .stall              (stall),
    .flush              (flush),
    .new_program_counter(new_program_counter),
    .stall_timeout      (stall_timeout)
`ifdef PIPELINE_STALL_COUNTER_EN
    ,
    .stall_count_clear  (stall_count_clear),
    .stall_cycle_count  (stall_cycle_count)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic addRow(input logic rst, input logic id, input logic ex,
                        input logic exc, input logic [31:0] vec,
                        input logic [5:0] expStall, input logic expFlush,
                        input logic [31:0] expPc, input logic expTimeout);
    vectors[nRows].rst        = rst;
    vectors[nRows].id         = id;
    vectors[nRows].ex         = ex;
    vectors[nRows].exc        = exc;
    vectors[nRows].vec        = vec;
    vectors[nRows].expStall   = expStall;
    vectors[nRows].expFlush   = expFlush;
    vectors[nRows].expPc      = expPc;
    vectors[nRows].expTimeout = expTimeout;
    nRows++;
  endtask

  task automatic clearInputs();
    stall_request_id  = 1'b0;
    stall_request_ex  = 1'b0;
    exception_request = 1'b0;
    exception_vector  = 32'd0;
`ifdef PIPELINE_STALL_COUNTER_EN
    stall_count_clear = 1'b0;
`endif
  endtask

  // Pulse reset low for about one cycle and release it on a falling edge.
  task automatic pulseReset();
    @(negedge clock);
    clearInputs();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Drive one cycle of inputs after the falling edge, let the combinational
  // stall settle, then compare everything visible before the next rising edge.
  task automatic applyStimulus(input int row);
    if (vectors[row].rst) pulseReset();
    @(negedge clock);
    stall_request_id  = vectors[row].id;
    stall_request_ex  = vectors[row].ex;
    exception_request = vectors[row].exc;
    exception_vector  = vectors[row].vec;
    #1;
    checkOutput($sformatf("row%0d.stall", row), 32'(stall), 32'(vectors[row].expStall));
    checkOutput($sformatf("row%0d.flush", row), 32'(flush), 32'(vectors[row].expFlush));
    checkOutput($sformatf("row%0d.pc", row), new_program_counter, vectors[row].expPc);
    checkOutput($sformatf("row%0d.timeout", row), 32'(stall_timeout),
                32'(vectors[row].expTimeout));
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    nRows       = 0;
    clearInputs();
    reset = 1'b0;

    // Idle after reset release: everything quiet.
    for (int i = 0; i < 10; i++) addRow(0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    // Three ID stalls, one idle, three ID stalls: runs never reach 4.
    for (int i = 0; i < 3; i++) addRow(0, 1, 0, 0, 0, 6'h07, 0, 0, 0);
    addRow(0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) addRow(0, 1, 0, 0, 0, 6'h07, 0, 0, 0);
    addRow(0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    // ID stall, then EX+ID together (EX wins); 4th stalled edge trips watchdog.
    for (int i = 0; i < 3; i++) addRow(0, 1, 0, 0, 0, 6'h07, 0, 0, 0);
    addRow(0, 1, 1, 0, 0, 6'h0F, 0, 0, 0);
    addRow(0, 0, 0, 0, 0, 6'h00, 0, 0, 1);
    // Reset clears the sticky flag.
    addRow(1, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    // ID held 6 cycles: flag visible after the 4th stalled edge and sticky.
    for (int i = 0; i < 4; i++) addRow(0, 1, 0, 0, 0, 6'h07, 0, 0, 0);
    for (int i = 0; i < 2; i++) addRow(0, 1, 0, 0, 0, 6'h07, 0, 0, 1);
    for (int i = 0; i < 2; i++) addRow(0, 0, 0, 0, 0, 6'h00, 0, 0, 1);
    // Exception while EX stalls: stall drops that cycle, 2-cycle flush,
    // later requests during FLUSH (incl. stalls) are ignored.
    addRow(1, 0, 1, 0, 0, 6'h0F, 0, 0, 0);
    addRow(0, 0, 1, 1, 32'h180, 6'h00, 0, 0, 0);
    addRow(0, 1, 1, 1, 32'h200, 6'h00, 1, 32'h180, 0);
    addRow(0, 0, 1, 1, 32'h200, 6'h00, 1, 32'h180, 0);
    addRow(0, 0, 1, 0, 0, 6'h0F, 0, 32'h180, 0);
    addRow(0, 0, 0, 0, 0, 6'h00, 0, 32'h180, 0);

    pulseReset();
    for (int r = 0; r < nRows; r++) applyStimulus(r);

    // Reset asserted mid-FLUSH: flush drops without waiting for a clock.
    @(negedge clock);
    clearInputs();
    exception_request = 1'b1;
    exception_vector  = 32'h0000_0440;
    @(negedge clock);
    exception_request = 1'b0;
    stall_request_id  = 1'b1;
    #1;
    checkOutput("midFlush.flushBefore", 32'(flush), 32'd1);
    checkOutput("midFlush.pcBefore", new_program_counter, 32'h0000_0440);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midFlush.flushAsync", 32'(flush), 32'd0);
    checkOutput("midFlush.pcAsync", new_program_counter, 32'd0);
    checkOutput("midFlush.stallInReset", 32'(stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    // Back in RUN: the held ID request is honoured immediately.
    checkOutput("afterReset.stallRun", 32'(stall), 32'h07);
    checkOutput("afterReset.flush", 32'(flush), 32'd0);

`ifdef PIPELINE_STALL_COUNTER_EN
    pulseReset();
    checkOutput("count.reset", stall_cycle_count, 32'd0);
    @(negedge clock);
    stall_request_ex = 1'b1;
    repeat (5) @(negedge clock);
    stall_request_ex = 1'b0;
    #1;
    checkOutput("count.five", stall_cycle_count, 32'd5);
    @(negedge clock);
    #1;
    checkOutput("count.holdIdle", stall_cycle_count, 32'd5);
    stall_request_id  = 1'b1;
    stall_count_clear = 1'b1;
    @(negedge clock);
    stall_count_clear = 1'b0;
    stall_request_id  = 1'b0;
    #1;
    checkOutput("count.clearWins", stall_cycle_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Central sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). Sits beside the stage modules.
- Merges stall requests from ID (load-use hazard) and EX (multi-cycle operation) into one per-stage stall vector.
- Sequences pipeline flushes on exception or redirect requests and supplies the redirect PC.
- Watches for pipeline deadlock with a consecutive-stall watchdog.

Parameters:
FLUSH_CYCLES, 1, number of cycles flush stays asserted per redirect (range 1..15)
STALL_TIMEOUT, 255, consecutive stalled cycles that trip the watchdog (range 1..65535)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
stall_request_id  input  1  ID stage needs one more cycle (load-use hazard)
stall_request_ex  input  1  EX stage busy with a multi-cycle operation
exception_request  input  1  single-cycle pulse requesting a flush/redirect
exception_vector  input  32  redirect target PC, sampled with exception_request
stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage
flush  output  1  clear all pipeline registers this cycle
new_program_counter  output  32  redirect PC, valid while flush=1
stall_timeout  output  1  sticky watchdog error flag

Behaviour:
- Reset (reset=0, async): state=RUN, flush=0, new_program_counter=0, flush counter=0, watchdog counter=0, stall_timeout=0. The stall output is 0 while reset=0.
- FSM states:
  - RUN: normal operation.
  - FLUSH: redirect in progress.
- stall (combinational from state and inputs, zero latency):
  - FLUSH state: 6'b000000.
  - RUN with exception_request=1: 6'b000000. An exception overrides stalls in the same cycle.
  - RUN with stall_request_ex=1: 6'b001111. EX has priority over ID.
  - RUN with only stall_request_id=1: 6'b000111.
  - Otherwise: 6'b000000.
- RUN -> FLUSH:
  - Triggered at the rising edge where exception_request=1.
  - Registers flush=1 and new_program_counter=exception_vector.
  - Loads the flush counter with FLUSH_CYCLES-1.
  - flush is registered and asserts one cycle after the request.
- FLUSH:
  - flush=1 every cycle; the counter decrements each cycle.
  - When the counter is 0, the next edge returns to RUN and sets flush=0.
  - new_program_counter holds its value until the next redirect.
  - Total flush width is exactly FLUSH_CYCLES cycles.
- exception_request while in FLUSH is ignored (no requeue, no vector update).
- stall_request_* while in FLUSH is ignored. The requester must hold its request and re-present it after FLUSH.
- Watchdog counter (16 bit):
  - Increments on each edge where stall[0]=1.
  - Clears to 0 on any edge where stall[0]=0.
  - Saturates at STALL_TIMEOUT.
  - When the count reaches STALL_TIMEOUT, stall_timeout sets at that edge and stays set until reset. It does not alter stall behaviour.
- Reset asserted mid-FLUSH: flush drops immediately (async), state returns to RUN.

Optional Feature:
- Macro: PIPELINE_STALL_COUNTER_EN.
- Defined:
  - Adds output stall_cycle_count (32 bit) and input stall_count_clear (1 bit).
  - The counter increments on each edge with stall[0]=1 and wraps from 0xFFFFFFFF to 0.
  - stall_count_clear=1 forces 0 at the edge and takes priority over increment.
  - Reset value is 0.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package pipeline_defines holds:
  - Stall masks: STALL_NONE=6'b000000, STALL_FROM_ID=6'b000111, STALL_FROM_EX=6'b001111.
  - FSM encoding: RUN=1'b0, FLUSH=1'b1.
  - Stall bit index constants.
- One natural sub-module: stall_watchdog.
  - Contains the saturating counter and the sticky flag.
  - Inputs: stall[0], clock, reset. Parameter: STALL_TIMEOUT.

Test Plan:
1. Reset release, no requests for 10 cycles -> stall=000000, flush=0, stall_timeout=0 throughout.
2. stall_request_id=1 for 3 cycles, then stall_request_ex=1 and stall_request_id=1 together -> stall=000111 for 3 cycles, then 001111; drop both -> 000000 the same cycle.
3. FLUSH_CYCLES=2; exception_request pulse with exception_vector=0x00000180 while stall_request_ex=1 -> stall=000000 that cycle; flush=1 for exactly the next 2 cycles; new_program_counter=0x00000180; stall reasserts 001111 after flush drops.
4. Second exception_request (vector 0x00000200) during FLUSH -> ignored; new_program_counter stays 0x00000180; flush width unchanged.
5. STALL_TIMEOUT=4; stall_request_id held 6 cycles -> stall_timeout rises at 4th stalled edge and stays 1 after the request drops. Separately, 3 stalled cycles, 1 idle, 3 stalled -> stall_timeout stays 0.
6. Assert reset=0 mid-FLUSH -> flush=0 immediately; after release, state RUN. With PIPELINE_STALL_COUNTER_EN: 5 stalled cycles -> stall_cycle_count=5; stall_count_clear pulse together with a stall -> count=0.
